// File: rtl/pry2oht_pkg.sv
// Shared helpers for priority-to-one-hot trees: level count, power checks and the
// bit offsets of the per-level group-valid vectors packed into one chain.
package pry2oht_pkg;

    function automatic int levels(input int width, input int split);
        int l = 0;
        int w = width;
        while (w > 1 && split > 1) begin
            w = w / split;
            l++;
        end
        return l;
    endfunction

    function automatic bit is_pow(input int value, input int base);
        int v = value;
        if (base < 2 || value < base) return 1'b0;
        while (v > 1 && (v % base) == 0) v = v / base;
        return v == 1;
    endfunction

    // Level l group-valid vector is WIDTH/SPLIT**l bits wide; level 0 is the input itself.
    function automatic int grp_off(input int width, input int split, input int level);
        int off = 0;
        int w = width;
        for (int l = 0; l < level; l++) begin
            off += w;
            w = w / split;
        end
        return off;
    endfunction

endpackage

// File: rtl/pry2oht_base.sv
// Flat LSB-first priority-to-one-hot encoder used at every tree node.
module pry2oht_base
    import pry2oht_pkg::*;
#(
    parameter int WIDTH          = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] pry,
    output logic [WIDTH-1:0] oht,
    output logic             vld
);

    assign vld = |pry;

    if (IMPLEMENTATION == 0) begin : g_arith
        // Two's-complement trick isolates the lowest set bit.
        assign oht = pry & (~pry + {{(WIDTH-1){1'b0}}, 1'b1});
    end else begin : g_scan
        always_comb begin
            oht = '0;
            for (int i = WIDTH-1; i >= 0; i--) begin
                if (pry[i]) begin
                    oht    = '0;
                    oht[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pry2oht_pipe_stage.sv
// One tree level: picks the winning sub-group in every group and masks the losers,
// optionally followed by a valid/ready register slice.
module pry2oht_pipe_stage
    import pry2oht_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int LEVEL          = 0,
    parameter bit REG            = 1'b1,
    parameter int IMPLEMENTATION = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_vld,
    output logic                                  in_rdy,
    input  logic [WIDTH-1:0]                      in_oht,
    input  logic [WIDTH/(SPLIT**LEVEL)-1:0]       in_grp,
    output logic                                  out_vld,
    input  logic                                  out_rdy,
    output logic [WIDTH-1:0]                      out_oht,
    output logic [WIDTH/(SPLIT**(LEVEL+1))-1:0]   out_grp
);

    localparam int SB = SPLIT ** LEVEL;
    localparam int GO = WIDTH / (SB * SPLIT);

    logic [WIDTH-1:0] oht_next;
    logic [GO-1:0]    grp_next;

    genvar gi, gj;
    for (gi = 0; gi < GO; gi++) begin : g_grp
        logic [SPLIT-1:0] br;

        pry2oht_base #(
            .WIDTH          (SPLIT),
            .IMPLEMENTATION (IMPLEMENTATION)
        ) u_base (
            .pry (in_grp[gi*SPLIT +: SPLIT]),
            .oht (br),
            .vld (grp_next[gi])
        );

        // Only the winning branch keeps its already one-hot sub-group.
        for (gj = 0; gj < SPLIT; gj++) begin : g_sub
            assign oht_next[(gi*SPLIT+gj)*SB +: SB] = in_oht[(gi*SPLIT+gj)*SB +: SB] & {SB{br[gj]}};
        end
    end

    if (REG) begin : g_reg
        logic            v_reg;
        logic [WIDTH-1:0] oht_reg;
        logic [GO-1:0]    grp_reg;

        assign in_rdy = !v_reg || out_rdy;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_reg   <= 1'b0;
                oht_reg <= '0;
                grp_reg <= '0;
            end else if (in_rdy) begin
                v_reg <= in_vld;
                if (in_vld) begin
                    oht_reg <= oht_next;
                    grp_reg <= grp_next;
                end
            end
        end

        assign out_vld = v_reg;
        assign out_oht = oht_reg;
        assign out_grp = grp_reg;
    end else begin : g_comb
        logic unused_clk;
        assign unused_clk = clk ^ rst_n;
        assign in_rdy     = out_rdy;
        assign out_vld    = in_vld;
        assign out_oht    = oht_next;
        assign out_grp    = grp_next;
    end

endmodule

// File: rtl/pry2oht_pipe.sv
// Pipelined, flow-controlled priority-to-one-hot converter built from a SPLIT-ary tree
// of stages; MSB-first priority is a bit reversal around an LSB-first tree.
module pry2oht_pipe
    import pry2oht_pkg::*;
#(
    parameter int                              WIDTH          = 32,
    parameter int                              SPLIT          = 2,
    parameter logic [levels(WIDTH, SPLIT)-1:0] PIPE           = '1,
    parameter bit                              MSB_FIRST      = 1'b0,
    parameter int                              IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_vld,
    output logic             s_rdy,
    input  logic [WIDTH-1:0] pry,
    output logic             m_vld,
    input  logic             m_rdy,
    output logic [WIDTH-1:0] oht,
    output logic             vld
);

    localparam int LEVELS   = levels(WIDTH, SPLIT);
    localparam int GRP_BITS = grp_off(WIDTH, SPLIT, LEVELS + 1);

    if (!is_pow(SPLIT, 2)) begin : g_bad_split
        $error("pry2oht_pipe: SPLIT must be a power of 2 and at least 2");
    end
    if (!is_pow(WIDTH, SPLIT)) begin : g_bad_width
        $error("pry2oht_pipe: WIDTH must be SPLIT**LEVELS with LEVELS >= 1");
    end
    if ($bits(PIPE) != LEVELS) begin : g_bad_pipe
        $error("pry2oht_pipe: PIPE must have one bit per tree level");
    end

    logic [LEVELS:0]     stage_vld;
    logic [LEVELS:0]     stage_rdy;
    logic [WIDTH-1:0]    stage_oht [LEVELS+1];
    logic [GRP_BITS-1:0] grp_chain;
    logic [WIDTH-1:0]    pry_in;
    logic [WIDTH-1:0]    oht_tree;

    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
        if (MSB_FIRST) begin : g_msb
            assign pry_in[gi] = pry[WIDTH-1-gi];
            assign oht[gi]    = oht_tree[WIDTH-1-gi];
        end else begin : g_lsb
            assign pry_in[gi] = pry[gi];
            assign oht[gi]    = oht_tree[gi];
        end
    end

    // Leaf level treats every input bit as a one-bit group that is its own valid.
    assign stage_vld[0]           = s_vld;
    assign s_rdy                  = stage_rdy[0];
    assign stage_oht[0]           = pry_in;
    assign grp_chain[WIDTH-1:0]   = pry_in;

    for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
        localparam int GI   = WIDTH / (SPLIT ** gi);
        localparam int IOFF = grp_off(WIDTH, SPLIT, gi);

        pry2oht_pipe_stage #(
            .WIDTH          (WIDTH),
            .SPLIT          (SPLIT),
            .LEVEL          (gi),
            .REG            (PIPE[gi]),
            .IMPLEMENTATION (IMPLEMENTATION)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_vld  (stage_vld[gi]),
            .in_rdy  (stage_rdy[gi]),
            .in_oht  (stage_oht[gi]),
            .in_grp  (grp_chain[IOFF +: GI]),
            .out_vld (stage_vld[gi+1]),
            .out_rdy (stage_rdy[gi+1]),
            .out_oht (stage_oht[gi+1]),
            .out_grp (grp_chain[IOFF+GI +: GI/SPLIT])
        );
    end

    assign stage_rdy[LEVELS] = m_rdy;
    assign m_vld             = stage_vld[LEVELS];
    assign oht_tree          = stage_oht[LEVELS];
    assign vld               = grp_chain[GRP_BITS-1];

endmodule

// File: tb/tb_pry2oht_pipe.sv
// Self-checking bench: four configurations of pry2oht_pipe against a queue-based model
// that finds the winning bit by plain scanning, plus directed literal expectations.
module tb_pry2oht_pipe;

    localparam int NDUT = 4;
    localparam int DW   [NDUT] = '{32, 32, 64, 64};
    localparam int NLAT [NDUT] = '{5, 5, 0, 1};
    localparam bit DMSB [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_vld_d [NDUT];
    logic        m_rdy_d [NDUT];
    logic [63:0] pry_d   [NDUT];
    logic        s_rdy_w [NDUT];
    logic        m_vld_w [NDUT];
    logic        vld_w   [NDUT];
    logic [31:0] o32     [2];
    logic [63:0] o64     [2];
    logic [63:0] oht_w   [NDUT];

    assign oht_w[0] = {32'b0, o32[0]};
    assign oht_w[1] = {32'b0, o32[1]};
    assign oht_w[2] = o64[0];
    assign oht_w[3] = o64[1];

    pry2oht_pipe #(.WIDTH(32), .SPLIT(2), .PIPE(5'b11111), .MSB_FIRST(1'b0), .IMPLEMENTATION(0)) d0 (
        .clk(clk), .rst_n(rst_n), .s_vld(s_vld_d[0]), .s_rdy(s_rdy_w[0]), .pry(pry_d[0][31:0]),
        .m_vld(m_vld_w[0]), .m_rdy(m_rdy_d[0]), .oht(o32[0]), .vld(vld_w[0]));
    pry2oht_pipe #(.WIDTH(32), .SPLIT(2), .PIPE(5'b11111), .MSB_FIRST(1'b1), .IMPLEMENTATION(1)) d1 (
        .clk(clk), .rst_n(rst_n), .s_vld(s_vld_d[1]), .s_rdy(s_rdy_w[1]), .pry(pry_d[1][31:0]),
        .m_vld(m_vld_w[1]), .m_rdy(m_rdy_d[1]), .oht(o32[1]), .vld(vld_w[1]));
    pry2oht_pipe #(.WIDTH(64), .SPLIT(4), .PIPE(3'b000), .MSB_FIRST(1'b0), .IMPLEMENTATION(0)) d2 (
        .clk(clk), .rst_n(rst_n), .s_vld(s_vld_d[2]), .s_rdy(s_rdy_w[2]), .pry(pry_d[2]),
        .m_vld(m_vld_w[2]), .m_rdy(m_rdy_d[2]), .oht(o64[0]), .vld(vld_w[2]));
    pry2oht_pipe #(.WIDTH(64), .SPLIT(4), .PIPE(3'b010), .MSB_FIRST(1'b0), .IMPLEMENTATION(1)) d3 (
        .clk(clk), .rst_n(rst_n), .s_vld(s_vld_d[3]), .s_rdy(s_rdy_w[3]), .pry(pry_d[3]),
        .m_vld(m_vld_w[3]), .m_rdy(m_rdy_d[3]), .oht(o64[1]), .vld(vld_w[3]));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h want %h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    // Winner is simply the first set bit met when scanning from the priority end.
    function automatic logic [63:0] ref_oht(input logic [63:0] p, input int w, input bit msb);
        logic [63:0] r = '0;
        bit found = 1'b0;
        for (int i = 0; i < w; i++) begin
            int b = msb ? (w - 1 - i) : i;
            if (!found && p[b]) begin
                r[b]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    logic [63:0] exp_q   [NDUT][$];
    int          acc_q   [NDUT][$];
    logic [63:0] log_oht [NDUT][$];
    logic        log_vld [NDUT][$];
    int          log_cyc [NDUT][$];

    logic        prev_stall [NDUT];
    logic [63:0] prev_oht   [NDUT];
    logic        prev_vld   [NDUT];

    // Handshakes are decided on the falling edge, where every input and ready is settled.
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (!rst_n) begin
                exp_q[k].delete();
                acc_q[k].delete();
                prev_stall[k] = 1'b0;
                if (NLAT[k] > 0) begin
                    chk("reset_m_vld", k, 64'(m_vld_w[k]), 64'd0);
                    chk("reset_oht", k, oht_w[k], 64'd0);
                    chk("reset_vld", k, 64'(vld_w[k]), 64'd0);
                end
            end else begin
                if (NLAT[k] == 0) chk("comb_s_rdy", k, 64'(s_rdy_w[k]), 64'(m_rdy_d[k]));
                if (m_vld_w[k]) begin
                    chk("onehot0", k, 64'($onehot0(oht_w[k])), 64'd1);
                    chk("vld_is_or_oht", k, 64'(vld_w[k]), 64'(|oht_w[k]));
                end
                if (prev_stall[k] && NLAT[k] > 0) begin
                    chk("stall_m_vld", k, 64'(m_vld_w[k]), 64'd1);
                    chk("stall_oht", k, oht_w[k], prev_oht[k]);
                    chk("stall_vld", k, 64'(vld_w[k]), 64'(prev_vld[k]));
                end
                if (s_vld_d[k] && s_rdy_w[k]) begin
                    exp_q[k].push_back(ref_oht(pry_d[k], DW[k], DMSB[k]));
                    acc_q[k].push_back(cyc);
                end
                if (m_vld_w[k] && m_rdy_d[k]) begin
                    chk("out_expected", k, 64'(exp_q[k].size() != 0), 64'd1);
                    if (exp_q[k].size() != 0) begin
                        logic [63:0] e;
                        int a;
                        e = exp_q[k].pop_front();
                        a = acc_q[k].pop_front();
                        chk("oht", k, oht_w[k], e);
                        chk("vld", k, 64'(vld_w[k]), 64'(|e));
                        chk("latency_ge_n", k, 64'((cyc - a) >= NLAT[k]), 64'd1);
                    end
                    log_oht[k].push_back(oht_w[k]);
                    log_vld[k].push_back(vld_w[k]);
                    log_cyc[k].push_back(cyc);
                end
                prev_stall[k] = m_vld_w[k] && !m_rdy_d[k];
                prev_oht[k]   = oht_w[k];
                prev_vld[k]   = vld_w[k];
            end
        end
    end

    task automatic clear_logs();
        for (int k = 0; k < NDUT; k++) begin
            log_oht[k].delete();
            log_vld[k].delete();
            log_cyc[k].delete();
        end
    endtask

    logic [63:0] vec     [4];
    logic [63:0] exp_lsb [4];
    logic [63:0] exp_msb [4];
    int t0;
    int idx;

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            s_vld_d[k] = 1'b0;
            m_rdy_d[k] = 1'b1;
            pry_d[k]   = '0;
        end

        chk("model_pin_lsb", 0, ref_oht(64'h0000_0000_0000_0C00, 32, 1'b0), 64'h0000_0000_0000_0400);
        chk("model_pin_msb", 1, ref_oht(64'h0000_0000_0000_0C01, 32, 1'b1), 64'h0000_0000_0000_0800);

        // Reset held with traffic offered.
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < NDUT; k++) begin
                s_vld_d[k] = 1'b1;
                pry_d[k]   = {$urandom, $urandom};
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < NDUT; k++) s_vld_d[k] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) chk("s_rdy_after_reset", k, 64'(s_rdy_w[k]), 64'd1);

        // Directed stream, both priority directions.
        vec     = '{64'h0, 64'h8000_0001, 64'h0001_0000, 64'hFFFF_FFFF};
        exp_lsb = '{64'h0, 64'h1, 64'h0001_0000, 64'h1};
        exp_msb = '{64'h0, 64'h8000_0000, 64'h0001_0000, 64'h8000_0000};
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 0) t0 = cyc;
            for (int k = 0; k < 2; k++) begin
                s_vld_d[k] = 1'b1;
                pry_d[k]   = vec[i];
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) s_vld_d[k] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("stream_count", k, 64'(log_oht[k].size()), 64'd4);
            if (log_oht[k].size() == 4) begin
                for (int i = 0; i < 4; i++) begin
                    chk(k == 0 ? "stream_lsb_oht" : "stream_msb_oht", k, log_oht[k][i], k == 0 ? exp_lsb[i] : exp_msb[i]);
                    chk("stream_cycle", k, 64'(log_cyc[k][i]), 64'(t0 + 5 + i));
                    chk("stream_vld", k, 64'(log_vld[k][i]), 64'(i != 0));
                end
            end
        end

        // Backpressure: output stalled for 7 cycles while the source keeps offering.
        clear_logs();
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                m_rdy_d[k] = 1'b0;
                s_vld_d[k] = 1'b1;
                pry_d[k]   = 64'h3 << idx;
            end
            @(negedge clk);
            chk("bp_s_rdy", 0, 64'(s_rdy_w[0]), 64'(c < 5));
            chk("bp_m_vld", 0, 64'(m_vld_w[0]), 64'(c >= 5));
            if (s_rdy_w[0]) idx++;
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                m_rdy_d[k] = 1'b1;
                s_vld_d[k] = (c < 4);
                pry_d[k]   = 64'h3 << idx;
            end
            @(negedge clk);
            if (s_vld_d[0] && s_rdy_w[0]) idx++;
        end
        repeat (8) @(posedge clk);
        #1;
        chk("bp_total", 0, 64'(log_oht[0].size()), 64'd9);
        chk("bp_total", 1, 64'(log_oht[1].size()), 64'd9);
        if (log_oht[0].size() == 9 && log_oht[1].size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                chk("bp_order_lsb", 0, log_oht[0][i], 64'h1 << i);
                chk("bp_order_msb", 1, log_oht[1][i], 64'h2 << i);
            end
        end

        // Random traffic and random backpressure on every configuration.
        for (int c = 0; c < 18000; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < NDUT; k++) begin
                s_vld_d[k] = ($urandom_range(3) != 0);
                m_rdy_d[k] = ($urandom_range(3) != 0);
                case ($urandom_range(3))
                    0:       pry_d[k] = '0;
                    1:       pry_d[k] = 64'h1 << $urandom_range(63);
                    2:       pry_d[k] = {$urandom, $urandom};
                    default: pry_d[k] = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                endcase
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < NDUT; k++) begin
            s_vld_d[k] = 1'b0;
            m_rdy_d[k] = 1'b1;
        end
        repeat (10) @(posedge clk);

        // Reset with three transfers in flight, then a lone transfer.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            s_vld_d[0] = 1'b1;
            pry_d[0]   = 64'h100 << i;
        end
        @(posedge clk); #1;
        s_vld_d[0] = 1'b0;
        rst_n      = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_logs();
        s_vld_d[0] = 1'b1;
        pry_d[0]   = 64'h0F00;
        t0         = cyc;
        @(posedge clk); #1;
        s_vld_d[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midreset_count", 0, 64'(log_oht[0].size()), 64'd1);
        if (log_oht[0].size() == 1) begin
            chk("midreset_oht", 0, log_oht[0][0], 64'h0100);
            chk("midreset_cycle", 0, 64'(log_cyc[0][0]), 64'(t0 + 5));
        end

        for (int k = 0; k < NDUT; k++) chk("drained", k, 64'(exp_q[k].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
